// File: rtl/adc_ltc2308_ctrl_if.sv
// CPU-side bus bundle for the LTC2308 controller: decoded select, 68000 strobes,
// word address and split read/write data paths.
interface adc_ltc2308_ctrl_if;
  logic        AdcSelect_H;
  logic        AS_L;
  logic        UDS_L;
  logic        LDS_L;
  logic        WE_L;
  logic [31:0] Address;
  logic [15:0] DataIn;
  logic [15:0] DataOut;

  modport master (output AdcSelect_H, AS_L, UDS_L, LDS_L, WE_L, Address, DataIn,
                  input  DataOut);
  modport slave  (input  AdcSelect_H, AS_L, UDS_L, LDS_L, WE_L, Address, DataIn,
                  output DataOut);
endinterface

// File: rtl/adc_ltc2308_ctrl.sv
// 68000 bus slave driving an LTC2308: a CTRL start runs a config frame then a
// convert frame over SPI and latches the 12-bit result.
module adc_ltc2308_ctrl #(
  parameter int CONVST_CYCLES = 2,
  parameter int CONV_CYCLES   = 40,
  parameter int SCLK_DIV      = 2
) (
  input  logic                 Clock,
  input  logic                 Reset_H,
  adc_ltc2308_ctrl_if.slave    bus,
  output logic                 ADC_CONVST,
  output logic                 ADC_SCLK,
  output logic                 ADC_DIN,
  input  logic                 ADC_DOUT
);
  localparam int MAX_A = (CONVST_CYCLES > CONV_CYCLES) ? CONVST_CYCLES : CONV_CYCLES;
  localparam int MAX_B = (MAX_A > SCLK_DIV) ? MAX_A : SCLK_DIV;
  localparam int CW    = $clog2(MAX_B + 1);

  typedef enum logic [2:0] {S_IDLE, S_CONVST, S_WAIT, S_SHIFT, S_DONE} state_t;

  state_t        r_state;
  logic [CW-1:0] r_cnt;
  logic [3:0]    r_bit;
  logic          r_phase;
  logic          r_frame;
  logic [11:0]   r_shift;
  logic [11:0]   r_result;
  logic [5:0]    r_cfg;
  logic          r_busy, r_done, r_ovr;
  logic          r_acc_d;

  logic          w_acc, w_first, w_wr, w_rd, w_start;
  logic [1:0]    w_sel;
  logic [11:0]   w_cfg_vec;
  logic [15:0]   w_rdata;
  logic          w_unused;

  assign w_acc     = bus.AdcSelect_H & ~bus.AS_L;
  assign w_first   = w_acc & ~r_acc_d;
  assign w_sel     = bus.Address[2:1];
  assign w_wr      = w_first & ~bus.WE_L;
  assign w_rd      = w_first & bus.WE_L;
  assign w_start   = w_wr & (w_sel == 2'd0) & ~bus.UDS_L & bus.DataIn[15];
  assign w_cfg_vec = {r_cfg, 6'b0};
  assign w_unused  = ^{bus.Address[31:3], bus.Address[0], bus.DataIn[14:6]};

  always_comb begin
    w_rdata = 16'h0000;
    case (w_sel)
      2'd0:    w_rdata = {10'b0, r_cfg};
      2'd1:    w_rdata = {13'b0, r_ovr, r_done, r_busy};
      2'd2:    w_rdata = {4'b0, r_result};
      default: w_rdata = 16'h0000;
    endcase
  end

  assign bus.DataOut = (w_acc & bus.WE_L) ? w_rdata : 16'hzzzz;

  always_ff @(posedge Clock) begin
    if (Reset_H) begin
      r_state    <= S_IDLE;
      r_cnt      <= '0;
      r_bit      <= 4'd0;
      r_phase    <= 1'b0;
      r_frame    <= 1'b0;
      r_shift    <= 12'h000;
      r_result   <= 12'h000;
      r_cfg      <= 6'h00;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_ovr      <= 1'b0;
      r_acc_d    <= 1'b0;
      ADC_CONVST <= 1'b0;
      ADC_SCLK   <= 1'b0;
      ADC_DIN    <= 1'b0;
    end else begin
      r_acc_d <= w_acc;
      if (w_rd && w_sel == 2'd1) r_ovr  <= 1'b0;
      if (w_rd && w_sel == 2'd2) r_done <= 1'b0;
      // A CTRL write during a transaction must not disturb the config in flight.
      if (w_wr && w_sel == 2'd0) begin
        if (r_state != S_IDLE) begin
          if (w_start) r_ovr <= 1'b1;
        end else if (!bus.LDS_L) begin
          r_cfg <= bus.DataIn[5:0];
        end
      end

      case (r_state)
        S_IDLE: if (w_start) begin
          r_state    <= S_CONVST;
          r_busy     <= 1'b1;
          r_frame    <= 1'b0;
          r_cnt      <= '0;
          ADC_CONVST <= 1'b1;
        end
        S_CONVST: begin
          r_cnt <= r_cnt + 1'b1;
          if (r_cnt == CW'(CONVST_CYCLES - 1)) begin
            r_state    <= S_WAIT;
            r_cnt      <= '0;
            ADC_CONVST <= 1'b0;
          end
        end
        S_WAIT: begin
          r_cnt <= r_cnt + 1'b1;
          if (r_cnt == CW'(CONV_CYCLES - 1)) begin
            r_state  <= S_SHIFT;
            r_cnt    <= '0;
            r_bit    <= 4'd11;
            r_phase  <= 1'b0;
            ADC_SCLK <= 1'b0;
            ADC_DIN  <= w_cfg_vec[11];
          end
        end
        S_SHIFT: begin
          r_cnt <= r_cnt + 1'b1;
          // DOUT has been stable since the previous falling SCLK edge.
          if (r_phase && r_cnt == '0) r_shift <= {r_shift[10:0], ADC_DOUT};
          if (r_cnt == CW'(SCLK_DIV - 1)) begin
            r_cnt <= '0;
            if (!r_phase) begin
              r_phase  <= 1'b1;
              ADC_SCLK <= 1'b1;
            end else begin
              r_phase  <= 1'b0;
              ADC_SCLK <= 1'b0;
              if (r_bit == 4'd0) begin
                r_state <= S_DONE;
                ADC_DIN <= 1'b0;
              end else begin
                r_bit   <= r_bit - 4'd1;
                ADC_DIN <= w_cfg_vec[r_bit - 4'd1];
              end
            end
          end
        end
        S_DONE: begin
          if (!r_frame) begin
            r_frame    <= 1'b1;
            r_state    <= S_CONVST;
            r_cnt      <= '0;
            ADC_CONVST <= 1'b1;
          end else begin
            r_result <= r_shift;
            r_done   <= 1'b1;
            r_busy   <= 1'b0;
            r_frame  <= 1'b0;
            r_state  <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_adc_ltc2308_ctrl.sv
// Bench for adc_ltc2308_ctrl: LTC2308 pin model plus a register-level model of
// cfg/result/flags, driven by directed and $urandom bus transactions.
module tb_adc_ltc2308_ctrl;
  logic Clock = 1'b0;
  logic Reset_H;
  logic adc_convst, adc_sclk, adc_din, adc_dout;

  adc_ltc2308_ctrl_if bus ();

  adc_ltc2308_ctrl dut (
    .Clock      (Clock),
    .Reset_H    (Reset_H),
    .bus        (bus),
    .ADC_CONVST (adc_convst),
    .ADC_SCLK   (adc_sclk),
    .ADC_DIN    (adc_din),
    .ADC_DOUT   (adc_dout)
  );

  always #20 Clock = ~Clock;

  int n_chk = 0, n_fail = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  // ADC pin model: frame word chosen by CONVST count, MSB out after conversion,
  // next bit on every falling SCLK; DIN captured on rising SCLK.
  logic [11:0] f0w, f1w, cur;
  int          fidx = 0, bidx = 0;
  logic        din_q[$];

  always @(posedge adc_convst) fidx++;
  always @(negedge adc_convst) begin
    cur      = (fidx == 1) ? f0w : f1w;
    bidx     = 11;
    adc_dout = cur[11];
  end
  always @(negedge adc_sclk) if (bidx > 0) begin
    bidx--;
    adc_dout = cur[bidx];
  end
  always @(posedge adc_sclk) din_q.push_back(adc_din);

  // register-level model
  logic [5:0]  mcfg;
  logic [11:0] mres;

  task automatic bus_idle();
    bus.AdcSelect_H = 1'b0; bus.AS_L = 1'b1; bus.UDS_L = 1'b1; bus.LDS_L = 1'b1;
    bus.WE_L = 1'b1; bus.Address = 32'h0; bus.DataIn = 16'h0;
  endtask

  task automatic bus_write(input logic [31:0] addr, input logic [15:0] d,
                           input logic uds_n, input logic lds_n);
    @(negedge Clock);
    bus.AdcSelect_H = 1'b1; bus.AS_L = 1'b0; bus.WE_L = 1'b0;
    bus.UDS_L = uds_n; bus.LDS_L = lds_n; bus.Address = addr; bus.DataIn = d;
    @(negedge Clock);
    bus_idle();
  endtask

  task automatic bus_read(input logic [31:0] addr, input int hold, output logic [15:0] d);
    @(negedge Clock);
    bus.AdcSelect_H = 1'b1; bus.AS_L = 1'b0; bus.WE_L = 1'b1;
    bus.UDS_L = 1'b0; bus.LDS_L = 1'b0; bus.Address = addr;
    #1 d = bus.DataOut;
    repeat (hold) @(negedge Clock);
    bus_idle();
  endtask

  // Holds a STATUS read and counts clocks with busy set; bounded at 400.
  task automatic busy_watch(output int cnt);
    cnt = 0;
    bus.AdcSelect_H = 1'b1; bus.AS_L = 1'b0; bus.WE_L = 1'b1; bus.Address = 32'h2;
    for (int i = 0; i < 400; i++) begin
      #1;
      if (bus.DataOut[0] === 1'b1) cnt++;
      else if (cnt > 0 || i >= 2) break;
      @(negedge Clock);
    end
    bus_idle();
  endtask

  task automatic arm(input logic [11:0] a, input logic [11:0] b);
    f0w = a; f1w = b; fidx = 0; din_q.delete();
  endtask

  task automatic check_done(input string tag, input int dhold);
    logic [23:0] dv;
    logic [15:0] rd;
    dv = '0;
    chk({tag, "_din_n"}, din_q.size(), 24);
    foreach (din_q[i]) dv = {dv[22:0], din_q[i]};
    chk({tag, "_din"}, dv, {mcfg, 6'b0, mcfg, 6'b0});
    mres = f1w;
    bus_read(32'h2, 1, rd); chk({tag, "_st_done"}, rd, 16'h0002);
    bus_read(32'h4, dhold, rd); chk({tag, "_data"}, rd, {4'b0, mres});
    bus_read(32'h2, 1, rd); chk({tag, "_st_clr"}, rd, 16'h0000);
  endtask

  task automatic run_txn(input string tag, input logic [15:0] d, input logic uds_n,
                         input logic lds_n, input logic [11:0] a, input logic [11:0] b,
                         input int dhold);
    int          cnt;
    logic        started;
    logic [15:0] rd;
    arm(a, b);
    bus_write(32'h0, d, uds_n, lds_n);
    if (!lds_n) mcfg = d[5:0];
    started = !uds_n && d[15];
    busy_watch(cnt);
    chk({tag, "_busy"}, cnt, started ? 182 : 0);
    if (started) check_done(tag, dhold);
    else begin
      bus_read(32'h2, 1, rd); chk({tag, "_st_idle"}, rd, 16'h0000);
      bus_read(32'h4, 1, rd); chk({tag, "_data_keep"}, rd, {4'b0, mres});
    end
    bus_read(32'h0, 1, rd); chk({tag, "_cfg"}, rd, {10'b0, mcfg});
  endtask

  initial begin
    logic [15:0] rd;
    int          cnt;
    logic [15:0] d;
    bus_idle();
    adc_dout = 1'b0;
    f0w = '0; f1w = '0; cur = '0;
    mcfg = '0; mres = '0;
    Reset_H = 1'b1;
    repeat (3) @(negedge Clock);
    Reset_H = 1'b0;

    chk("rst_pins", {adc_convst, adc_sclk, adc_din}, 3'b000);
    for (int a = 0; a < 4; a++) begin
      bus_read(32'(a * 2), 1, rd);
      chk($sformatf("rst_rd%0d", a * 2), rd, 16'h0000);
    end

    run_txn("basic", 16'h8022, 1'b0, 1'b0, 12'h555, 12'hABC, 1);
    run_txn("hold5", 16'h8022, 1'b0, 1'b0, 12'h123, 12'hF0E, 5);

    // writes to the unused offset do nothing
    bus_write(32'h6, 16'h80FF, 1'b0, 1'b0);
    busy_watch(cnt); chk("off6_busy", cnt, 0);
    bus_read(32'h0, 1, rd); chk("off6_cfg", rd, {10'b0, mcfg});

    // start while busy: overrun, cfg untouched
    arm(12'h3C3, 12'h5A6);
    bus_write(32'h0, 16'h8022, 1'b0, 1'b0);
    repeat (48) @(negedge Clock);
    bus_write(32'h0, 16'h8011, 1'b0, 1'b0);
    bus_read(32'h2, 1, rd); chk("ovr_st", rd, 16'h0005);
    bus_read(32'h0, 1, rd); chk("ovr_cfg", rd, 16'h0022);
    bus_read(32'h2, 1, rd); chk("ovr_st_clr", rd, 16'h0001);
    busy_watch(cnt); chk("ovr_finished", (cnt > 0 && cnt < 182) ? 1 : 0, 1);
    check_done("ovr", 1);

    // synchronous reset in frame 1 while shifting
    arm(12'h111, 12'h777);
    bus_write(32'h0, 16'h8022, 1'b0, 1'b0);
    repeat (150) @(negedge Clock);
    Reset_H = 1'b1;
    @(negedge Clock);
    Reset_H = 1'b0;
    #1 chk("rstmid_pins", {adc_convst, adc_sclk, adc_din}, 3'b000);
    mcfg = '0; mres = '0;
    bus_read(32'h2, 1, rd); chk("rstmid_st", rd, 16'h0000);
    bus_read(32'h4, 1, rd); chk("rstmid_data", rd, 16'h0000);
    bus_read(32'h0, 1, rd); chk("rstmid_cfg", rd, 16'h0000);
    run_txn("after_rst", 16'h8033, 1'b0, 1'b0, 12'h9AB, 12'h246, 1);

    // upper-byte-only write starts with the old cfg
    run_txn("uds_only", 16'h80FF, 1'b0, 1'b1, 12'h0F0, 12'hC3A, 1);

    for (int k = 0; k < 8; k++) begin
      d = {($urandom_range(0, 3) != 0), 9'($urandom), 6'($urandom)};
      run_txn($sformatf("rnd%0d", k), d, ($urandom_range(0, 3) == 0),
              ($urandom_range(0, 3) == 0), 12'($urandom), 12'($urandom), 1);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
